// File: rtl/sigma_uart_pkg.sv
// Shared definitions for the sigma UART transmit and receive paths:
// FSM states, frame shape, line levels and the default baud divisor.
package sigma_uart_pkg;

    typedef enum logic [2:0] {
        UART_TX_IDLE   = 3'd0,
        UART_TX_START  = 3'd1,
        UART_TX_DATA   = 3'd2,
        UART_TX_PARITY = 3'd3,
        UART_TX_STOP   = 3'd4
    } uart_tx_state_t;

    localparam int   UART_DATA_BITS        = 8;
    localparam logic UART_LINE_IDLE        = 1'b1;
    localparam logic UART_LINE_START       = 1'b0;
    localparam logic UART_LINE_STOP        = 1'b1;
    localparam int   UART_DEFAULT_BAUD_DIV = 434;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic uart_even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/sigma_uart_tx_fifo.sv
// Transmit byte FIFO: power-of-two depth, registered not-full flag,
// count output, and a head-of-queue read that is valid whenever non-empty.
module sigma_uart_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     arst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     ready_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             ready_q, ready_d;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_push  = push_i & ready_q;
        do_pop   = pop_i & (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_ONE;
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_ONE;
        end
        // Ready is registered from the next count, so a pop while full only
        // re-opens the port on the cycle after that pop.
        ready_d = (count_d != FULL_CNT);
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign ready_o = ready_q;
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/sigma_uart_tx.sv
// sigma UART transmitter: FIFO-buffered 8N1 serialiser, or 8E1 when the
// SIGMA_UART_TX_PARITY_EN macro is defined.
module sigma_uart_tx
    import sigma_uart_pkg::*;
#(
    parameter int BAUD_DIV   = UART_DEFAULT_BAUD_DIV,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk_i,
    input  logic                          arst_i,
    input  logic                          tx_valid_i,
    input  logic [7:0]                    tx_data_i,
    output logic                          tx_ready_o,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o
);

    localparam logic [15:0] BAUD_RELOAD = 16'(BAUD_DIV - 1);
    localparam logic [2:0]  LAST_BIT    = 3'(UART_DATA_BITS - 1);

    uart_tx_state_t state_q, state_d;
    logic [15:0]    baud_q, baud_d;
    logic [7:0]     shift_q, shift_d;
    logic [2:0]     bit_q, bit_d;
    logic           tx_q, tx_d;
`ifdef SIGMA_UART_TX_PARITY_EN
    logic           parity_q, parity_d;
`endif

    logic           fifo_pop;
    logic           fifo_empty;
    logic [7:0]     fifo_rdata;
    logic           load_frame;
    logic           baud_done;

    sigma_uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk_i   (clk_i),
        .arst_i  (arst_i),
        .push_i  (tx_valid_i),
        .pop_i   (fifo_pop),
        .wdata_i (tx_data_i),
        .rdata_o (fifo_rdata),
        .ready_o (tx_ready_o),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt_o)
    );

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        shift_d    = shift_q;
        bit_d      = bit_q;
        tx_d       = tx_q;
`ifdef SIGMA_UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        fifo_pop   = 1'b0;
        load_frame = 1'b0;
        baud_done  = (baud_q == '0);

        // Every non-idle state holds its line level for one baud period.
        if (state_q != UART_TX_IDLE) begin
            baud_d = baud_done ? BAUD_RELOAD : (baud_q - 16'd1);
        end

        case (state_q)
            UART_TX_IDLE: begin
                tx_d = UART_LINE_IDLE;
                if (!fifo_empty) begin
                    load_frame = 1'b1;
                end
            end
            UART_TX_START: begin
                if (baud_done) begin
                    state_d = UART_TX_DATA;
                    tx_d    = shift_q[0];
                end
            end
            UART_TX_DATA: begin
                if (baud_done) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == LAST_BIT) begin
`ifdef SIGMA_UART_TX_PARITY_EN
                        state_d = UART_TX_PARITY;
                        tx_d    = parity_q;
`else
                        state_d = UART_TX_STOP;
                        tx_d    = UART_LINE_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = shift_q[1];
                    end
                end
            end
`ifdef SIGMA_UART_TX_PARITY_EN
            UART_TX_PARITY: begin
                if (baud_done) begin
                    state_d = UART_TX_STOP;
                    tx_d    = UART_LINE_STOP;
                end
            end
`endif
            UART_TX_STOP: begin
                if (baud_done) begin
                    if (!fifo_empty) begin
                        load_frame = 1'b1;
                    end else begin
                        state_d = UART_TX_IDLE;
                        tx_d    = UART_LINE_IDLE;
                    end
                end
            end
            default: begin
                state_d = UART_TX_IDLE;
                tx_d    = UART_LINE_IDLE;
            end
        endcase

        // Shared by IDLE and the end of STOP so back-to-back frames abut.
        if (load_frame) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
            bit_d    = '0;
            baud_d   = BAUD_RELOAD;
            state_d  = UART_TX_START;
            tx_d     = UART_LINE_START;
`ifdef SIGMA_UART_TX_PARITY_EN
            parity_d = uart_even_parity(fifo_rdata);
`endif
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q  <= UART_TX_IDLE;
            baud_q   <= '0;
            shift_q  <= '0;
            bit_q    <= '0;
            tx_q     <= UART_LINE_IDLE;
`ifdef SIGMA_UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            shift_q  <= shift_d;
            bit_q    <= bit_d;
            tx_q     <= tx_d;
`ifdef SIGMA_UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign tx_o   = tx_q;
    assign busy_o = (state_q != UART_TX_IDLE) | (fifo_cnt_o != '0);

endmodule

// File: tb/tb_sigma_uart_tx.sv
// Bench for sigma_uart_tx: two instances (BAUD_DIV 4 and 1) checked every cycle
// against a frame-timeline model of accepted bytes, plus directed scenarios.
module tb_sigma_uart_tx;

`ifdef SIGMA_UART_TX_PARITY_EN
    localparam int FBITS = 11;
`else
    localparam int FBITS = 10;
`endif
    localparam int B0   = 4;
    localparam int D0   = 8;
    localparam int B1   = 1;
    localparam int D1   = 4;
    localparam int NMAX = 512;

    logic       clk  = 1'b0;
    logic       arst = 1'b1;
    logic       v0 = 1'b0, v1 = 1'b0;
    logic [7:0] d0 = 8'h00, d1 = 8'h00;
    logic       r0, tx0, busy0;
    logic       r1, tx1, busy1;
    logic [3:0] cnt0;
    logic [2:0] cnt1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model: for every accepted byte, the edge it was pushed and the edges its frame spans.
    int         m_push  [2][NMAX];
    int         m_start [2][NMAX];
    int         m_end   [2][NMAX];
    logic [7:0] m_data  [2][NMAX];
    int         m_n     [2];

    sigma_uart_tx #(.BAUD_DIV(B0), .FIFO_DEPTH(D0)) u0 (
        .clk_i(clk), .arst_i(arst), .tx_valid_i(v0), .tx_data_i(d0),
        .tx_ready_o(r0), .tx_o(tx0), .busy_o(busy0), .fifo_cnt_o(cnt0)
    );

    sigma_uart_tx #(.BAUD_DIV(B1), .FIFO_DEPTH(D1)) u1 (
        .clk_i(clk), .arst_i(arst), .tx_valid_i(v1), .tx_data_i(d1),
        .tx_ready_o(r1), .tx_o(tx1), .busy_o(busy1), .fifo_cnt_o(cnt1)
    );

    always #5 clk = ~clk;

    function automatic int bdiv(input int u);
        return (u == 0) ? B0 : B1;
    endfunction

    function automatic int depth(input int u);
        return (u == 0) ? D0 : D1;
    endfunction

    // Bit k of a frame: start, eight data bits LSB first, optional even parity, stop.
    function automatic int frame_bit(input logic [7:0] d, input int k);
        if (k == 0) return 0;
        if (k <= 8) return int'(d[k-1]);
        if (FBITS == 11 && k == 9) return int'(^d);
        return 1;
    endfunction

    function automatic int model_cnt(input int u, input int t);
        int c = 0;
        for (int j = 0; j < m_n[u]; j++)
            if (m_push[u][j] <= t && m_start[u][j] > t) c++;
        return c;
    endfunction

    function automatic int model_active(input int u, input int t);
        for (int j = 0; j < m_n[u]; j++)
            if (m_start[u][j] <= t && t < m_end[u][j]) return 1;
        return 0;
    endfunction

    function automatic int model_line(input int u, input int t);
        for (int j = 0; j < m_n[u]; j++)
            if (m_start[u][j] <= t && t < m_end[u][j])
                return frame_bit(m_data[u][j], (t - m_start[u][j]) / bdiv(u));
        return 1;
    endfunction

    // A byte accepted at edge e starts at e+1, or when the previous frame ends.
    function automatic void model_push(input int u, input int e, input logic [7:0] d);
        int last_end = (m_n[u] > 0) ? m_end[u][m_n[u]-1] : 0;
        int s = (e + 1 > last_end) ? e + 1 : last_end;
        m_push[u][m_n[u]]  = e;
        m_start[u][m_n[u]] = s;
        m_end[u][m_n[u]]   = s + FBITS * bdiv(u);
        m_data[u][m_n[u]]  = d;
        m_n[u]++;
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    task automatic check_all();
        int c;
        c = model_cnt(0, cyc);
        chk("u0_tx",   int'(tx0),   model_line(0, cyc));
        chk("u0_cnt",  int'(cnt0),  c);
        chk("u0_rdy",  int'(r0),    int'(c < D0));
        chk("u0_busy", int'(busy0), int'(model_active(0, cyc) != 0 || c > 0));
        c = model_cnt(1, cyc);
        chk("u1_tx",   int'(tx1),   model_line(1, cyc));
        chk("u1_cnt",  int'(cnt1),  c);
        chk("u1_rdy",  int'(r1),    int'(c < D1));
        chk("u1_busy", int'(busy1), int'(model_active(1, cyc) != 0 || c > 0));
    endtask

    // One clock: drive inputs, predict acceptance, advance, check after the edge.
    task automatic tick(input logic va, input logic [7:0] da,
                        input logic vb, input logic [7:0] db,
                        output logic acc_a, output logic acc_b);
        v0 = va; d0 = da; v1 = vb; d1 = db;
        acc_a = 1'b0;
        acc_b = 1'b0;
        if (!arst) begin
            if (va && model_cnt(0, cyc) < depth(0)) begin
                model_push(0, cyc + 1, da);
                acc_a = 1'b1;
            end
            if (vb && model_cnt(1, cyc) < depth(1)) begin
                model_push(1, cyc + 1, db);
                acc_b = 1'b1;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        $display("cyc=%0d u0 v=%0b d=%02h acc=%0b tx=%0b cnt=%0d | u1 v=%0b d=%02h acc=%0b tx=%0b cnt=%0d",
                 cyc, va, da, acc_a, tx0, cnt0, vb, db, acc_b, tx1, cnt1);
        check_all();
    endtask

    task automatic idle(input int n);
        logic a, b;
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0, 8'h00, a, b);
    endtask

    initial begin
        logic       a, b;
        logic [7:0] fill [10];
        int         idx;
        int         s;

        m_n[0] = 0;
        m_n[1] = 0;

        // Held in reset: outputs must show the reset values.
        idle(2);
        arst = 1'b0;
        idle(2);

        // 0x55 at BAUD_DIV=4 and 0x80 at BAUD_DIV=1; line falls one cycle after the push.
        tick(1'b1, 8'h55, 1'b1, 8'h80, a, b);
        chk("push55_acc", int'(a), 1);
        tick(1'b0, 8'h00, 1'b0, 8'h00, a, b);
        chk("fall55", int'(tx0), 0);
        chk("fall80", int'(tx1), 0);
        idle(FBITS * B0 + 4);
        chk("idle55_busy", int'(busy0), 0);

        // Consecutive pushes, plus parity patterns 0x07 / 0x03.
        tick(1'b1, 8'hA5, 1'b1, 8'h07, a, b);
        tick(1'b1, 8'h3C, 1'b1, 8'h03, a, b);
        tick(1'b1, 8'h07, 1'b0, 8'h00, a, b);
        tick(1'b1, 8'h03, 1'b0, 8'h00, a, b);
        idle(4 * FBITS * B0 + 4);

        // FIFO fill: hold valid until ten bytes are in.
        for (int i = 0; i < 10; i++) fill[i] = 8'(8'h10 + i * 17);
        idx = 0;
        for (int n = 0; n < 400 && idx < 10; n++) begin
            tick(1'b1, fill[idx], 1'b0, 8'h00, a, b);
            if (a) idx++;
            if (n == 8) begin
                chk("fill_nine", idx, 9);
                chk("fill_rdy_low", int'(r0), 0);
                chk("fill_cnt_full", int'(cnt0), D0);
            end
        end
        chk("fill_all_taken", idx, 10);
        idle(FBITS * B0 * 10 + 10);

        // Randomised traffic on both instances.
        for (int n = 0; n < 400; n++)
            tick($urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 1) == 1, 8'($urandom), a, b);
        idle(FBITS * B0 * (D0 + 2) + 10);

        // Reset during data bit 3 of 0xFF with three bytes queued behind it.
        s = 0;
        tick(1'b1, 8'hFF, 1'b0, 8'h00, a, b);
        if (m_n[0] > 0) s = m_start[0][m_n[0]-1];
        tick(1'b1, 8'h11, 1'b0, 8'h00, a, b);
        tick(1'b1, 8'h22, 1'b0, 8'h00, a, b);
        tick(1'b1, 8'h33, 1'b0, 8'h00, a, b);
        for (int n = 0; n < 100 && cyc < s + 17; n++) idle(1);
        chk("pre_rst_cnt", int'(cnt0), 3);
        chk("pre_rst_tx", int'(tx0), 1);
        arst = 1'b1;
        #1;
        chk("rst_tx", int'(tx0), 1);
        chk("rst_cnt", int'(cnt0), 0);
        chk("rst_rdy", int'(r0), 1);
        chk("rst_busy", int'(busy0), 0);
        m_n[0] = 0;
        m_n[1] = 0;
        idle(2);
        arst = 1'b0;
        idle(FBITS * B0 + 10);
        chk("post_rst_busy", int'(busy0), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
